fp_div_iter: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider, OUT = A / B. Inverse operation of the team's combinational FP multiplier.
- Uses the same 32-bit format, special-value encodings and truncation (no rounding) policy, so both units can be swapped into the same datapath.
- Restoring radix-2 division produces one quotient bit per cycle.
- Sits in the FP execution stage behind a start/done handshake.

---
 rtl/fp_div_iter.sv | 170 +++++++++++++++++
 tb/tb_fp_div_iter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// Multi-cycle FP32 divider (OUT = A / B): restoring radix-2, one quotient bit per cycle, truncating.
// Fixed 29-cycle latency; start accepted only in IDLE and never in the done cycle; no queueing.
module fp_div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] OUT
);

  typedef enum logic [1:0] {IDLE, PREP, DIV, NORM} state_t;

  state_t             state, state_nxt;
  logic [31:0]        a_q, b_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mb_q;
  logic [24:0]        rem_q;
  logic [25:0]        q_q;
  logic [4:0]         cnt_q;
  logic               spec_q;
  logic [31:0]        spec_res_q;

  // Left shift that brings the leading one of a denormal fraction up to bit 23.
  function automatic logic [4:0] lead_shift(input logic [22:0] f);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 23; i++)
      if (f[i]) s = 5'(23 - i);
    return s;
  endfunction

  logic [7:0]        xa, xb;
  logic [22:0]       fa, fb;
  logic [4:0]        la, lb;
  logic [23:0]       ma, mb;
  logic signed [9:0] ea_eff, eb_eff, e_prep;
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, so;
  logic              spec_n;
  logic [31:0]       spec_res_n;

  always_comb begin
    xa     = a_q[30:23];
    xb     = b_q[30:23];
    fa     = a_q[22:0];
    fb     = b_q[22:0];
    so     = a_q[31] ^ b_q[31];
    la     = lead_shift(fa);
    lb     = lead_shift(fb);
    ma     = (xa == 8'd0) ? ({1'b0, fa} << la) : {1'b1, fa};
    mb     = (xb == 8'd0) ? ({1'b0, fb} << lb) : {1'b1, fb};
    ea_eff = (xa == 8'd0) ? 10'sd1 - $signed({5'd0, la}) : $signed({2'b00, xa});
    eb_eff = (xb == 8'd0) ? 10'sd1 - $signed({5'd0, lb}) : $signed({2'b00, xb});
    e_prep = ea_eff - eb_eff + 10'sd127;

    a_zero = (xa == 8'h00) && (fa == 23'd0);
    b_zero = (xb == 8'h00) && (fb == 23'd0);
    a_inf  = (xa == 8'hFF) && (fa == 23'd0);
    b_inf  = (xb == 8'hFF) && (fb == 23'd0);
    a_nan  = (xa == 8'hFF) && (fa != 23'd0);
    b_nan  = (xb == 8'hFF) && (fb != 23'd0);

    // Priority: NaN, then INF, then ZERO; the sign is kept even for NaN.
    spec_n     = 1'b1;
    spec_res_n = {so, 8'hFF, 23'h7FFFFF};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_res_n = {so, 8'hFF, 23'h7FFFFF};
    else if (a_inf || b_zero)
      spec_res_n = {so, 8'hFF, 23'h000000};
    else if (a_zero || b_inf)
      spec_res_n = {so, 8'h00, 23'h000000};
    else
      spec_n = 1'b0;
  end

  logic signed [9:0] e_n, sh_full;
  logic [23:0]       mant_n;
  logic [22:0]       mant_sh;
  logic [4:0]        sh;
  logic [31:0]       norm_res;
  logic [23:0]       rem_sub;

  always_comb begin
    if (q_q[25]) begin
      mant_n = q_q[25:2];
      e_n    = exp_q;
    end else begin
      mant_n = q_q[24:1];
      e_n    = exp_q - 10'sd1;
    end
    sh_full = 10'sd1 - e_n;
    sh      = (sh_full > 10'sd25) ? 5'd25 : sh_full[4:0];
    mant_sh = 23'(mant_n >> sh);
    if (e_n >= 10'sd255)
      norm_res = {sign_q, 8'hFF, 23'h000000};
    else if (e_n <= 10'sd0)
      norm_res = {sign_q, 8'h00, mant_sh};
    else
      norm_res = {sign_q, e_n[7:0], mant_n[22:0]};
    rem_sub = 24'(rem_q - {1'b0, mb_q});
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start && !done) state_nxt = PREP;
      PREP:    state_nxt = DIV;
      DIV:     if (cnt_q == 5'd25) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      done       <= 1'b0;
      OUT        <= '0;
    end else begin
      done <= (state == NORM);
      case (state)
        IDLE: if (start && !done) begin
          a_q <= A;
          b_q <= B;
        end
        PREP: begin
          sign_q     <= so;
          exp_q      <= e_prep;
          mb_q       <= mb;
          rem_q      <= {1'b0, ma};
          q_q        <= '0;
          cnt_q      <= '0;
          spec_q     <= spec_n;
          spec_res_q <= spec_res_n;
        end
        DIV: begin
          cnt_q <= cnt_q + 5'd1;
          if (rem_q >= {1'b0, mb_q}) begin
            q_q   <= {q_q[24:0], 1'b1};
            rem_q <= {rem_sub, 1'b0};
          end else begin
            q_q   <= {q_q[24:0], 1'b0};
            rem_q <= {rem_q[23:0], 1'b0};
          end
        end
        NORM: OUT <= spec_q ? spec_res_q : norm_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: directed corner cases, handshake and reset checks, plus random
// operands compared with an exact-arithmetic truncating reference model.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] OUT;

  int n_checks = 0;
  int n_errors = 0;

  fp_div_iter dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .OUT  (OUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Exact quotient from integer significands, truncated toward zero into FP32.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic         s;
    logic [7:0]   xa, xb;
    logic [22:0]  fa, fb;
    logic [127:0] ma, mb, n, fr;
    logic [31:0]  be;
    int           ea, eb, p, bexp, sh;
    s  = a[31] ^ b[31];
    xa = a[30:23]; xb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    if ((xa == 8'hFF && fa != 0) || (xb == 8'hFF && fb != 0) ||
        (a[30:0] == 0 && b[30:0] == 0) || (a[30:0] == 31'h7F800000 && b[30:0] == 31'h7F800000))
      return {s, 8'hFF, 23'h7FFFFF};
    if (a[30:0] == 31'h7F800000 || b[30:0] == 0)
      return {s, 8'hFF, 23'h0};
    if (a[30:0] == 0 || b[30:0] == 31'h7F800000)
      return {s, 31'h0};
    ma = (xa == 0) ? {105'd0, fa} : {104'd0, 1'b1, fa};
    mb = (xb == 0) ? {105'd0, fb} : {104'd0, 1'b1, fb};
    ea = (xa == 0) ? 1 : int'(xa);
    eb = (xb == 0) ? 1 : int'(xb);
    n  = (ma << 64) / mb;
    p  = 0;
    for (int i = 0; i < 128; i++) if (n[i]) p = i;
    bexp = p + ea - eb - 64 + 127;
    if (bexp >= 255) return {s, 8'hFF, 23'h0};
    if (bexp >= 1) begin
      be = bexp;
      fr = n >> (p - 23);
      return {s, be[7:0], fr[22:0]};
    end
    sh = eb - ea - 85;
    fr = (sh > 127) ? 128'd0 : (n >> sh);
    return {s, 8'h00, fr[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: r[30:0]  = 31'h0;
      3: begin r[30:23] = 8'h00; r[22:0] = r[22:0] >> $urandom_range(0, 22); end
      4: r[22:0]  = 23'h0;
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                        output logic [31:0] res, output int lat, output int busy_cnt);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    lat = -1; busy_cnt = 0; res = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (poke_at != 0 && k == poke_at) begin
        start = 1'b1; A = 32'h3F800000; B = 32'h40400000;
      end
      if (poke_at != 0 && k == poke_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k; res = OUT;
        break;
      end
    end
    start = 1'b0;
  endtask

  logic [31:0] dir_a [11] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                              32'h00000000, 32'h7F800000, 32'h3F800000, 32'h7F000000,
                              32'h00800000, 32'h00000001, 32'h00400000};
  logic [31:0] dir_b [11] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                              32'h00000000, 32'h7F800000, 32'h7F800000, 32'h3F000000,
                              32'h40000000, 32'h40000000, 32'h00400000};
  logic [31:0] dir_y [11] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'hFF800000,
                              32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h7F800000,
                              32'h00400000, 32'h00000000, 32'h3F800000};

  initial begin
    logic [31:0] res, r1, r2, ra, rb;
    int          lat, bc, first, second;
    logic        b30, b31, seen;

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", OUT, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(dir_a[i], dir_b[i], 0, res, lat, bc);
      check($sformatf("dir%0d_out", i), res, dir_y[i]);
      check($sformatf("dir%0d_lat", i), 32'(lat), 32'd29);
      check($sformatf("dir%0d_busy", i), 32'(bc), 32'd28);
    end

    // Start re-asserted mid-operation must not disturb the running divide.
    run_op(32'h40C00000, 32'h40000000, 5, res, lat, bc);
    check("poke_out", res, 32'h40400000);
    check("poke_lat", 32'(lat), 32'd29);

    // Start held high through done: next accept is the cycle after done.
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    first = -1; second = -1; r1 = '0; r2 = '0; b30 = 1'b1; b31 = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 30) b30 = busy;
      if (k == 31) b31 = busy;
      if (first >= 0 && done) begin
        second = k; r2 = OUT;
        break;
      end
      if (first < 0 && done) begin
        first = k; r1 = OUT;
        A = 32'h3F800000; B = 32'h40400000;
      end
    end
    start = 1'b0;
    check("hold_first_lat", 32'(first), 32'd29);
    check("hold_first_out", r1, 32'h40400000);
    check("hold_busy_k30", {31'd0, b30}, 32'd0);
    check("hold_busy_k31", {31'd0, b31}, 32'd1);
    check("hold_second_lat", 32'(second), 32'd59);
    check("hold_second_out", r2, 32'h3EAAAAAA);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_out", OUT, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", {31'd0, seen}, 32'd0);
    run_op(32'h40C00000, 32'h40000000, 0, res, lat, bc);
    check("post_rst_out", res, 32'h40400000);
    check("post_rst_lat", 32'(lat), 32'd29);

    for (int i = 0; i < 200; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      run_op(ra, rb, 0, res, lat, bc);
      check($sformatf("rnd_%08h_%08h", ra, rb), res, ref_div(ra, rb));
      check("rnd_lat", 32'(lat), 32'd29);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
